// File: rtl/pw_prog.sv
// pw_prog: password enrollment block. A code of four switch-index digits is
// entered, the switches are released, the code is re-entered to confirm, and
// on a full match the stored code is updated with a one-cycle code_valid pulse.
// Optional feature macro: PW_PROG_TIMEOUT_EN adds an inactivity timeout that
// forces ERR after TIMEOUT_CYCLES idle cycles in ENTER, RELEASE or CONFIRM.
module pw_prog #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h0123,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  sw,
  input  logic        prog,
  output logic [15:0] code,
  output logic        code_valid,
  output logic [5:0]  states,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4
);

  localparam int unsigned SW_W   = 10;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_DIG  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned SEG_W  = 7;

  // Blank digit marker; real digits are 0..9 so 4'hF never collides.
  localparam logic [DIG_W-1:0] DIG_BLANK = 4'hF;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;

  // Reject a zero timeout at elaboration; the counter compares against TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("pw_prog: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_ENTER   = 6'b000010,
    S_RELEASE = 6'b000100,
    S_CONFIRM = 6'b001000,
    S_DONE    = 6'b010000,
    S_ERR     = 6'b100000
  } state_t;

  state_t                        state_q, state_d;
  logic [SW_W-1:0]               sw_q, sw_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [N_DIG-1:0][DIG_W-1:0]   dig_q, dig_d;
  logic [15:0]                   code_q, code_d;
  logic                          code_valid_q, code_valid_d;
  logic [N_DIG:0][SEG_W-1:0]     hex_q, hex_d;

  logic [SW_W-1:0]               rise;
  logic                          press_one;
  logic                          press_multi;
  logic [DIG_W-1:0]              idx;
  logic                          show_dig;

`ifdef PW_PROG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_run;
  logic             tmo_hit;
`endif

  // Active-low seven-segment decode of one digit; anything above 9 is blank.
  function automatic logic [SEG_W-1:0] seg7(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Press detection: rising edges only, classified as single or multi press.
  always_comb begin
    rise        = sw & ~sw_q;
    press_one   = (rise != '0) && ((rise & (rise - SW_W'(1))) == '0);
    press_multi = (rise != '0) && !press_one;
    idx         = '0;
    for (int i = 0; i < int'(SW_W); i++) begin
      if (rise[i]) idx = DIG_W'(i);
    end
  end

  // Next-state, buffer, code and display computation.
  always_comb begin
    state_d      = state_q;
    sw_d         = sw;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    hex_d        = hex_q;
    show_dig     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (prog) begin
          state_d = S_ENTER;
          dig_d   = {N_DIG{DIG_BLANK}};
          cnt_d   = '0;
        end
      end
      S_ENTER: begin
        if (press_multi) begin
          state_d = S_ERR;
        end else if (press_one) begin
          dig_d[cnt_q] = idx;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_DIG - 1)) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (sw == '0) begin
          state_d = S_CONFIRM;
          cnt_d   = '0;
        end
      end
      S_CONFIRM: begin
        if (press_multi) begin
          state_d = S_ERR;
        end else if (press_one) begin
          if (idx != dig_q[cnt_q]) begin
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_DIG - 1)) begin
              state_d      = S_DONE;
              code_d       = dig_q;
              code_valid_d = 1'b1;
            end
          end
        end
      end
      S_DONE, S_ERR: begin
        if (sw == '0) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PW_PROG_TIMEOUT_EN
    // Idle timeout: only fires when this cycle has no press and no transition.
    tmo_run = (state_q == S_ENTER) || (state_q == S_RELEASE) || (state_q == S_CONFIRM);
    tmo_hit = tmo_run && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_d   = '0;
    if (tmo_hit && !press_one && (state_d == state_q)) begin
      state_d = S_ERR;
    end else if (tmo_run && !press_one && (state_d == state_q)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
`endif

    show_dig = (state_d == S_ENTER) || (state_d == S_RELEASE) ||
               (state_d == S_CONFIRM) || (state_d == S_DONE);
    for (int i = 0; i < int'(N_DIG); i++) begin
      hex_d[i] = show_dig ? seg7(dig_d[i]) : SEG_BLANK;
    end
    case (state_d)
      S_ENTER:   hex_d[N_DIG] = SEG_P;
      S_CONFIRM: hex_d[N_DIG] = SEG_C;
      S_DONE:    hex_d[N_DIG] = SEG_D;
      S_ERR:     hex_d[N_DIG] = SEG_E;
      default:   hex_d[N_DIG] = SEG_BLANK;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sw_q         <= '0;
      cnt_q        <= '0;
      dig_q        <= {N_DIG{DIG_BLANK}};
      code_q       <= DEFAULT_CODE;
      code_valid_q <= 1'b0;
      hex_q        <= {(N_DIG + 1){SEG_BLANK}};
`ifdef PW_PROG_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sw_q         <= sw_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      hex_q        <= hex_d;
`ifdef PW_PROG_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign states     = state_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign HEX0       = hex_q[0];
  assign HEX1       = hex_q[1];
  assign HEX2       = hex_q[2];
  assign HEX3       = hex_q[3];
  assign HEX4       = hex_q[4];

endmodule

// File: tb/tb_pw_prog.sv
// Self-checking bench for pw_prog: scenario tasks plus a code_valid scoreboard.
module tb_pw_prog;

  logic        clk;
  logic        rst;
  logic [9:0]  sw;
  logic        prog;
  logic [15:0] code;
  logic        code_valid;
  logic [5:0]  states;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb[$];

  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_ENTER   = 6'b000010;
  localparam logic [5:0] ST_RELEASE = 6'b000100;
  localparam logic [5:0] ST_CONFIRM = 6'b001000;
  localparam logic [5:0] ST_DONE    = 6'b010000;
  localparam logic [5:0] ST_ERR     = 6'b100000;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] GL_P  = 7'h0C;
  localparam logic [6:0] GL_C  = 7'h46;
  localparam logic [6:0] GL_D  = 7'h21;
  localparam logic [6:0] GL_E  = 7'h06;

  pw_prog #(.DEFAULT_CODE(16'h0123), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .sw(sw), .prog(prog),
    .code(code), .code_valid(code_valid), .states(states),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // Scoreboard consumer: every code_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst && code_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL code_valid_unexpected: pulse with code=%h, none expected", code);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (code !== e) begin
          n_fail++;
          $display("FAIL code_valid_code: got %h expected %h", code, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sw = '0; prog = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start_prog();
    prog = 1'b1; tick(1); prog = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = '0; prog = 1'b0;
    tick(2);
    n_tests++;
    if (states !== ST_IDLE || code !== 16'h0123 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: states=%b code=%h cv=%b expected %b 0123 0",
               states, code, code_valid, ST_IDLE);
    end
    n_tests++;
    if ({HEX4, HEX3, HEX2, HEX1, HEX0} !== {5{BLANK}}) begin
      n_fail++;
      $display("FAIL reset_hex: got %h %h %h %h %h expected all 7f", HEX4, HEX3, HEX2, HEX1, HEX0);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_mismatch();
    do_reset();
    start_prog();
    sw = 10'h020; tick(1);
    sw = 10'h060; tick(1);
    sw = 10'h0E0; tick(1);
    sw = 10'h1E0; tick(1);
    n_tests++;
    if (states !== ST_RELEASE) begin
      n_fail++;
      $display("FAIL mismatch_release: states=%b expected %b", states, ST_RELEASE);
    end
    sw = '0; tick(1);
    sw = 10'h020; tick(1);
    sw = 10'h060; tick(1);
    sw = 10'h260; tick(1);
    n_tests++;
    if (states !== ST_ERR || HEX4 !== GL_E || HEX0 !== BLANK || code !== 16'h0123) begin
      n_fail++;
      $display("FAIL mismatch_err: states=%b hex4=%h hex0=%h code=%h expected %b %h 7f 0123",
               states, HEX4, HEX0, code, ST_ERR, GL_E);
    end
    sw = '0; tick(1);
    n_tests++;
    if (states !== ST_IDLE || code !== 16'h0123) begin
      n_fail++;
      $display("FAIL mismatch_idle: states=%b code=%h expected %b 0123", states, code, ST_IDLE);
    end
  endtask

  task automatic test_enroll();
    start_prog();
    n_tests++;
    if (states !== ST_ENTER || HEX4 !== GL_P || HEX0 !== BLANK) begin
      n_fail++;
      $display("FAIL enroll_enter: states=%b hex4=%h hex0=%h expected %b %h 7f",
               states, HEX4, HEX0, ST_ENTER, GL_P);
    end
    sw = 10'h001; tick(1);
    n_tests++;
    if (HEX0 !== seg(0) || HEX1 !== BLANK) begin
      n_fail++;
      $display("FAIL enroll_digit0: hex0=%h hex1=%h expected %h 7f", HEX0, HEX1, seg(0));
    end
    sw = 10'h003; tick(1);
    sw = 10'h007; tick(1);
    sw = 10'h00F; tick(1);
    n_tests++;
    if (states !== ST_RELEASE || HEX3 !== seg(3) || HEX2 !== seg(2) || HEX4 !== BLANK) begin
      n_fail++;
      $display("FAIL enroll_release: states=%b hex3=%h hex2=%h hex4=%h", states, HEX3, HEX2, HEX4);
    end
    sw = '0; tick(1);
    n_tests++;
    if (states !== ST_CONFIRM || HEX4 !== GL_C) begin
      n_fail++;
      $display("FAIL enroll_confirm: states=%b hex4=%h expected %b %h", states, HEX4, ST_CONFIRM, GL_C);
    end
    sw = 10'h001; tick(1);
    sw = 10'h003; tick(1);
    sw = 10'h007; tick(1);
    n_tests++;
    if (states !== ST_CONFIRM || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enroll_partial: states=%b cv=%b expected %b 0", states, code_valid, ST_CONFIRM);
    end
    sb.push_back(16'h3210);
    sw = 10'h00F; tick(1);
    n_tests++;
    if (states !== ST_DONE || code !== 16'h3210 || code_valid !== 1'b1 || HEX4 !== GL_D) begin
      n_fail++;
      $display("FAIL enroll_done: states=%b code=%h cv=%b hex4=%h expected %b 3210 1 %h",
               states, code, code_valid, HEX4, ST_DONE, GL_D);
    end
    tick(1);
    n_tests++;
    if (code_valid !== 1'b0 || states !== ST_DONE) begin
      n_fail++;
      $display("FAIL enroll_pulse_width: cv=%b states=%b expected 0 %b", code_valid, states, ST_DONE);
    end
    sw = '0; tick(1);
    n_tests++;
    if (states !== ST_IDLE || code !== 16'h3210) begin
      n_fail++;
      $display("FAIL enroll_idle: states=%b code=%h expected %b 3210", states, code, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    start_prog();
    sw = 10'h002; tick(1);
    sw = 10'h006; tick(1);
    sw = 10'h00E; tick(1);
    sw = 10'h01E; tick(1);
    sw = '0;      tick(1);
    sw = 10'h002; tick(1);
    sw = 10'h006; tick(1);
    n_tests++;
    if (states !== ST_CONFIRM) begin
      n_fail++;
      $display("FAIL resetmid_confirm: states=%b expected %b", states, ST_CONFIRM);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (states !== ST_IDLE || code !== 16'h0123 ||
        {HEX4, HEX3, HEX2, HEX1, HEX0} !== {5{BLANK}}) begin
      n_fail++;
      $display("FAIL resetmid_state: states=%b code=%h hex=%h %h %h %h %h expected %b 0123 blank",
               states, code, HEX4, HEX3, HEX2, HEX1, HEX0, ST_IDLE);
    end
    sw = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_multi_press();
    start_prog();
    sw = 10'h003; tick(1);
    n_tests++;
    if (states !== ST_ERR || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_err: states=%b cv=%b expected %b 0", states, code_valid, ST_ERR);
    end
    sw = '0; tick(1);
    n_tests++;
    if (states !== ST_IDLE || code !== 16'h0123) begin
      n_fail++;
      $display("FAIL multi_idle: states=%b code=%h expected %b 0123", states, code, ST_IDLE);
    end
  endtask

  task automatic test_repeat_prog_held();
    prog = 1'b1;
    tick(1);
    sw = 10'h010; tick(1);
    tick(3);
    n_tests++;
    if (states !== ST_ENTER || HEX0 !== seg(4) || HEX1 !== BLANK) begin
      n_fail++;
      $display("FAIL repeat_hold: states=%b hex0=%h hex1=%h expected %b %h 7f",
               states, HEX0, HEX1, ST_ENTER, seg(4));
    end
    for (int i = 0; i < 3; i++) begin
      sw = '0;      tick(1);
      sw = 10'h010; tick(1);
    end
    n_tests++;
    if (states !== ST_RELEASE ||
        {HEX3, HEX2, HEX1, HEX0} !== {seg(4), seg(4), seg(4), seg(4)}) begin
      n_fail++;
      $display("FAIL repeat_buf: states=%b hex=%h %h %h %h expected %b 19 19 19 19",
               states, HEX3, HEX2, HEX1, HEX0, ST_RELEASE);
    end
    for (int i = 0; i < 4; i++) begin
      sw = '0; tick(1);
      if (i == 3) sb.push_back(16'h4444);
      sw = 10'h010; tick(1);
    end
    n_tests++;
    if (states !== ST_DONE || code !== 16'h4444) begin
      n_fail++;
      $display("FAIL repeat_done: states=%b code=%h expected %b 4444", states, code, ST_DONE);
    end
    sw = '0; tick(1);
    n_tests++;
    if (states !== ST_IDLE) begin
      n_fail++;
      $display("FAIL prog_held_idle: states=%b expected %b", states, ST_IDLE);
    end
    tick(1);
    n_tests++;
    if (states !== ST_ENTER) begin
      n_fail++;
      $display("FAIL prog_held_restart: states=%b expected %b", states, ST_ENTER);
    end
    prog = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    start_prog();
    tick(10);
    n_tests++;
    if (states !== ST_ENTER) begin
      n_fail++;
      $display("FAIL timeout_early: states=%b expected %b", states, ST_ENTER);
    end
    tick(15);
    n_tests++;
`ifdef PW_PROG_TIMEOUT_EN
    if (states !== ST_ERR) begin
      n_fail++;
      $display("FAIL timeout_err: states=%b expected %b", states, ST_ERR);
    end
`else
    if (states !== ST_ENTER) begin
      n_fail++;
      $display("FAIL timeout_wait: states=%b expected %b", states, ST_ENTER);
    end
`endif
    do_reset();
  endtask

  initial begin
    rst = 1'b1; sw = '0; prog = 1'b0;
    test_reset();
    test_mismatch();
    test_enroll();
    test_reset_mid();
    test_multi_press();
    test_repeat_prog_held();
    test_timeout();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected code_valid pulses never seen, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
